// File: rtl/e_scale_requant_pipe.sv
// e_scale_requant_pipe: scales accumulator rows by the E_scale tail, then
// round-shifts by rank, clamps to OUT_W and counts clamped lanes.
// Ports: clk/reset_n, in_* valid/ready beat (mode,row,tail,rank),
// out_* valid/ready beat (row), sat_clr/sat_cnt saturation counter.
// Option macro E_SCALE_RELU_EN: zero negative lanes after the clamp.
module e_scale_requant_pipe #(
  parameter int LANES  = 32,
  parameter int W88    = 24,
  parameter int W18    = 16,
  parameter int TAIL_W = 16,
  parameter int RANK_W = 8,
  parameter int OUT_W  = 8,
  // derived from the above; do not override
  parameter int IN_BUS_W = (LANES*W88 > 2*LANES*W18)
                         ? LANES*W88 : 2*LANES*W18
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [IN_BUS_W-1:0]      in_row,
  input  logic [2*TAIL_W-1:0]      in_tail,
  input  logic [2*RANK_W-1:0]      in_rank,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*LANES*OUT_W-1:0] out_row,
  input  logic                     sat_clr,
  output logic [15:0]              sat_cnt
);

  localparam int PROD_W = W88 + TAIL_W + 1;
  localparam int NL     = 2 * LANES;
  localparam int SC_W   = $clog2(NL + 1);
  localparam int XW     = PROD_W - OUT_W + 2;

  localparam logic signed [PROD_W:0] SMAX =
    {{XW{1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PROD_W:0] SMIN =
    {{XW{1'b1}}, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic                  mode;
    logic [IN_BUS_W-1:0]   row;
    logic [2*TAIL_W-1:0]   tail;
    logic [2*RANK_W-1:0]   rank;
  } s0_t;

  typedef struct packed {
    logic                        mode;
    logic [NL-1:0][PROD_W-1:0]   prod;
    logic [2*RANK_W-1:0]         rank;
  } s1_t;

  s0_t s0_q;
  s1_t s1_d;
  s1_t s1_q;
  logic s0_v;
  logic s1_v;
  logic ld0;
  logic ld1;
  logic ld2;
  logic [2*LANES*OUT_W-1:0] out_d;
  logic [SC_W-1:0] nsat_d;
  logic [SC_W-1:0] nsat_q;
  logic [OUT_W:0] rq;
  logic [16:0] sat_sum;

  // A stage may load whenever the stage ahead is empty or draining,
  // so bubbles collapse instead of stalling the input.
  assign ld2      = !out_valid || out_ready;
  assign ld1      = !s1_v || ld2;
  assign ld0      = !s0_v || ld1;
  assign in_ready = ld0;

  function automatic logic signed [PROD_W-1:0] mul(
    input logic signed [PROD_W-1:0] px,
    input logic [TAIL_W-1:0]        t
  );
    logic signed [PROD_W-1:0] tx;
    tx = $signed(PROD_W'({1'b0, t}));
    return px * tx;
  endfunction

  // Returns {clamped, value}; the flag reflects the clamp before ReLU.
  function automatic logic [OUT_W:0] requant(
    input logic signed [PROD_W-1:0] p,
    input logic [RANK_W-1:0]        r
  );
    logic signed [PROD_W:0] s;
    logic signed [PROD_W:0] rnd;
    logic [OUT_W-1:0]       v;
    logic                   f;
    s   = {p[PROD_W-1], p};
    rnd = '0;
    if (r >= RANK_W'(PROD_W)) begin
      s = '0;
    end else if (r != '0) begin
      rnd = (PROD_W+1)'(1) << (r - RANK_W'(1));
      s   = (s + rnd) >>> r;
    end
    f = 1'b0;
    if (s > SMAX) begin
      v = SMAX[OUT_W-1:0];
      f = 1'b1;
    end else if (s < SMIN) begin
      v = SMIN[OUT_W-1:0];
      f = 1'b1;
    end else begin
      v = s[OUT_W-1:0];
    end
`ifdef E_SCALE_RELU_EN
    if (v[OUT_W-1]) v = '0;
`endif
    return {f, v};
  endfunction

  always_comb begin
    s1_d      = '0;
    s1_d.mode = s0_q.mode;
    s1_d.rank = s0_q.rank;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < LANES; i++) begin
        if (s0_q.mode) begin
          s1_d.prod[c*LANES+i] = mul(
            PROD_W'($signed(s0_q.row[(c*LANES+i)*W18 +: W18])),
            s0_q.tail[c*TAIL_W +: TAIL_W]);
        end else if (c == 0) begin
          s1_d.prod[i] = mul(
            PROD_W'($signed(s0_q.row[i*W88 +: W88])),
            s0_q.tail[TAIL_W-1:0]);
        end
      end
    end
  end

  // Channel 1 stays zero and uncounted in 8x8 mode.
  always_comb begin
    out_d  = '0;
    nsat_d = '0;
    rq     = '0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < LANES; i++) begin
        rq = requant(s1_q.prod[c*LANES+i],
                     s1_q.rank[c*RANK_W +: RANK_W]);
        if (s1_q.mode || c == 0) begin
          out_d[(c*LANES+i)*OUT_W +: OUT_W] = rq[OUT_W-1:0];
          nsat_d = nsat_d + SC_W'(rq[OUT_W]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_v      <= 1'b0;
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
      s0_q      <= '0;
      s1_q      <= '0;
      out_row   <= '0;
      nsat_q    <= '0;
    end else begin
      if (ld0) begin
        s0_v <= in_valid;
        if (in_valid) begin
          s0_q <= {in_mode, in_row, in_tail, in_rank};
        end
      end
      if (ld1) begin
        s1_v <= s0_v;
        if (s0_v) s1_q <= s1_d;
      end
      if (ld2) begin
        out_valid <= s1_v;
        if (s1_v) begin
          out_row <= out_d;
          nsat_q  <= nsat_d;
        end
      end
    end
  end

  // Clamped lanes are counted when their beat leaves the block.
  assign sat_sum = {1'b0, sat_cnt} + 17'(nsat_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

endmodule
